// File: rtl/isa_cycle_ctrl_pkg.sv
// ============================================================================
// Module      : isa_cycle_ctrl_pkg
// Description : Shared definitions for the ISA cycle controller: the state
//               encoding, the default phase timings and a helper for sizing
//               the shared phase counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_cycle_ctrl_pkg;

    // Cycle controller states, 3-bit encoding IDLE=0 .. DONE=5
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    // Default phase timings, in clocks
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_STROBE_CYC = 6;
    localparam int DEF_HOLD_CYC   = 2;
    localparam int DEF_WAIT_MAX   = 255;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // The counter only ever holds (parameter - 1), so clog2 of the largest
    // parameter is enough; never let the width collapse to zero.
    function automatic int cnt_width(input int largest);
        return (largest <= 2) ? 1 : $clog2(largest);
    endfunction

endpackage

`default_nettype wire

// File: rtl/isa_cycle_ctrl_sync2.sv
// ============================================================================
// Module      : isa_cycle_ctrl_sync2
// Description : Two-flop synchroniser for a single asynchronous level.
//               Ports: clk_i clock, rst_ni async active-low reset,
//               d_i asynchronous input, q_o synchronised output.
//               RST_VAL sets the value both flops take during reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isa_cycle_ctrl_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic ff1_q;
    logic ff2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ff1_q <= RST_VAL;
            ff2_q <= RST_VAL;
        end else begin
            ff1_q <= d_i;
            ff2_q <= ff1_q;
        end
    end

    assign q_o = ff2_q;

endmodule

`default_nettype wire

// File: rtl/isa_cycle_ctrl.sv
// ============================================================================
// Module      : isa_cycle_ctrl
// Description : Sequencer feeding the ISA strobe stage. Latches a decoded
//               Zorro III I/O request, times address setup / strobe / hold,
//               stretches the strobe while IOCHRDY is low (bounded by
//               WAIT_MAX), captures read data and returns a one-clock ack.
//   Inputs  : clk, nRESET (async, active low), req/rnw/addr_in/wdata
//             (request), nSLAVEN (Z3 slave enable, high = abort),
//             IOCHRDY (async channel ready), isa_din (ISA data in)
//   Outputs : en/read (to strobe stage), isa_addr/isa_dout/isa_doe (ISA
//             address and write data), rdata/ack/err (completion),
//             busy (not idle)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isa_cycle_ctrl
    import isa_cycle_ctrl_pkg::*;
#(
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int STROBE_CYC = DEF_STROBE_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int WAIT_MAX   = DEF_WAIT_MAX,
    parameter int DW         = 16
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          req,
    input  logic          rnw,
    input  logic [15:0]   addr_in,
    input  logic [DW-1:0] wdata,
    input  logic          nSLAVEN,
    input  logic          IOCHRDY,
    input  logic [DW-1:0] isa_din,
    output logic          en,
    output logic          read,
    output logic [15:0]   isa_addr,
    output logic [DW-1:0] isa_dout,
    output logic          isa_doe,
    output logic [DW-1:0] rdata,
    output logic          ack,
    output logic          err,
    output logic          busy
);

    localparam int CW = cnt_width(max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, WAIT_MAX));

    localparam logic [CW-1:0] C_SETUP_LD  = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] C_STROBE_LD = CW'(STROBE_CYC - 1);
    localparam logic [CW-1:0] C_HOLD_LD   = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] C_WAIT_LD   = CW'(WAIT_MAX - 1);
    localparam logic [CW-1:0] C_ONE       = CW'(1);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          en_q;
    logic          read_q;
    logic [15:0]   addr_q;
    logic [DW-1:0] dout_q;
    logic          doe_q;
    logic [DW-1:0] rdata_q;
    logic          ack_q;
    logic          err_q;
    logic          busy_q;
    logic          rdy_s;

    // Idle channel is "ready", so the synchroniser comes out of reset at 1
    isa_cycle_ctrl_sync2 #(
        .RST_VAL (1'b1)
    ) u_rdy_sync (
        .clk_i  (clk),
        .rst_ni (nRESET),
        .d_i    (IOCHRDY),
        .q_o    (rdy_s)
    );

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            doe_q   <= 1'b0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req && !nSLAVEN) begin
                        addr_q  <= addr_in;
                        read_q  <= rnw;
                        dout_q  <= wdata;
                        doe_q   <= ~rnw;
                        err_q   <= 1'b0;
                        cnt_q   <= C_SETUP_LD;
                        busy_q  <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (nSLAVEN) begin
                        // Abort before the strobe: nothing on the bus to read
                        err_q   <= 1'b1;
                        cnt_q   <= C_HOLD_LD;
                        state_q <= ST_HOLD;
                    end else if (cnt_q == '0) begin
                        en_q    <= 1'b1;
                        cnt_q   <= C_STROBE_LD;
                        state_q <= ST_STROBE;
                    end else begin
                        cnt_q <= cnt_q - C_ONE;
                    end
                end
                ST_STROBE: begin
                    if (nSLAVEN || (cnt_q == '0 && rdy_s)) begin
                        // nIOR is still asserted this clock, so isa_din is valid
                        if (read_q) rdata_q <= isa_din;
                        en_q    <= 1'b0;
                        err_q   <= nSLAVEN;
                        cnt_q   <= C_HOLD_LD;
                        state_q <= ST_HOLD;
                    end else if (cnt_q == '0) begin
                        cnt_q   <= C_WAIT_LD;
                        state_q <= ST_WAIT;
                    end else begin
                        cnt_q <= cnt_q - C_ONE;
                    end
                end
                ST_WAIT: begin
                    if (nSLAVEN || rdy_s || cnt_q == '0) begin
                        if (read_q) rdata_q <= isa_din;
                        en_q    <= 1'b0;
                        // Flag abort or timeout; a genuine ready ends cleanly
                        err_q   <= nSLAVEN || !rdy_s;
                        cnt_q   <= C_HOLD_LD;
                        state_q <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q - C_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        ack_q   <= 1'b1;
                        doe_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - C_ONE;
                    end
                end
                ST_DONE: begin
                    // Four-phase handshake: req must drop before a new cycle
                    if (!req) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    en_q    <= 1'b0;
                    doe_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign en       = en_q;
    assign read     = read_q;
    assign isa_addr = addr_q;
    assign isa_dout = dout_q;
    assign isa_doe  = doe_q;
    assign rdata    = rdata_q;
    assign ack      = ack_q;
    assign err      = err_q;
    assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_isa_cycle_ctrl.sv
// ============================================================================
// Module      : tb_isa_cycle_ctrl
// Description : Directed self-checking bench for isa_cycle_ctrl. Two
//               instances share stimulus: default timing and WAIT_MAX=8.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isa_cycle_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          nRESET, req, rnw, nSLAVEN, IOCHRDY;
    logic [15:0]   addr_in;
    logic [DW-1:0] wdata, isa_din;

    logic          en0, read0, doe0, ack0, err0, busy0;
    logic [15:0]   addr0;
    logic [DW-1:0] dout0, rdata0;
    logic          en8, read8, doe8, ack8, err8, busy8;
    logic [15:0]   addr8;
    logic [DW-1:0] dout8, rdata8;

    logic          sel8 = 1'b0;
    logic          m_en, m_read, m_doe, m_ack, m_err, m_busy;
    logic [15:0]   m_addr;
    logic [DW-1:0] m_dout, m_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    isa_cycle_ctrl u_dut (
        .clk(clk), .nRESET(nRESET), .req(req), .rnw(rnw), .addr_in(addr_in),
        .wdata(wdata), .nSLAVEN(nSLAVEN), .IOCHRDY(IOCHRDY), .isa_din(isa_din),
        .en(en0), .read(read0), .isa_addr(addr0), .isa_dout(dout0),
        .isa_doe(doe0), .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
    );

    isa_cycle_ctrl #(.WAIT_MAX(8)) u_dut8 (
        .clk(clk), .nRESET(nRESET), .req(req), .rnw(rnw), .addr_in(addr_in),
        .wdata(wdata), .nSLAVEN(nSLAVEN), .IOCHRDY(IOCHRDY), .isa_din(isa_din),
        .en(en8), .read(read8), .isa_addr(addr8), .isa_dout(dout8),
        .isa_doe(doe8), .rdata(rdata8), .ack(ack8), .err(err8), .busy(busy8)
    );

    assign m_en    = sel8 ? en8    : en0;
    assign m_read  = sel8 ? read8  : read0;
    assign m_doe   = sel8 ? doe8   : doe0;
    assign m_ack   = sel8 ? ack8   : ack0;
    assign m_err   = sel8 ? err8   : err0;
    assign m_busy  = sel8 ? busy8  : busy0;
    assign m_addr  = sel8 ? addr8  : addr0;
    assign m_dout  = sel8 ? dout8  : dout0;
    assign m_rdata = sel8 ? rdata8 : rdata0;

    typedef struct {
        int            en_first;
        int            en_cnt;
        int            ack_k;
        int            ack_cnt;
        logic          err;
        logic [DW-1:0] rdata;
        logic [15:0]   addr;
        logic [DW-1:0] dout;
        bit            dir_ok;
        bit            doe_ok;
        bit            overlap;
    } res_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and observe the monitored instance at every falling
    // edge. k counts falling edges after the req sample edge (k=0 is the
    // state right after that edge). IOCHRDY is low for lo_from <= k < lo_to,
    // nSLAVEN rises at k == abort_k.
    task automatic run(input logic rw, input logic [15:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] din, input int lo_from, input int lo_to,
                       input int abort_k, input bit hold_req, output res_t r);
        r.en_first = -1; r.en_cnt = 0; r.ack_k = -1; r.ack_cnt = 0;
        r.err = 1'bx; r.rdata = 'x; r.addr = 'x; r.dout = 'x;
        r.dir_ok = 1'b1; r.doe_ok = 1'b1; r.overlap = 1'b0;
        @(negedge clk);
        req = 1'b1; rnw = rw; addr_in = a; wdata = wd; isa_din = din;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (m_en) begin
                r.en_cnt++;
                if (r.en_first < 0) r.en_first = k;
                if (m_read !== rw) r.dir_ok = 1'b0;
            end
            if (m_en && m_ack) r.overlap = 1'b1;
            if (m_ack) begin
                r.ack_cnt++;
                if (r.ack_k < 0) begin
                    r.ack_k = k; r.err = m_err; r.rdata = m_rdata;
                    r.addr = m_addr; r.dout = m_dout;
                    if (!hold_req) req = 1'b0;
                end
            end else if (r.ack_k < 0 && m_doe !== ~rw) begin
                r.doe_ok = 1'b0;
            end
            IOCHRDY = !(k >= lo_from && k < lo_to);
            if (k == abort_k) nSLAVEN = 1'b1;
            if (r.ack_k >= 0 && k >= r.ack_k + 3) break;
        end
        IOCHRDY = 1'b1;
    endtask

    initial begin
        res_t r;
        int   en_seen;

        nRESET = 1'b0; req = 1'b0; rnw = 1'b0; nSLAVEN = 1'b0; IOCHRDY = 1'b1;
        addr_in = '0; wdata = '0; isa_din = '0;
        repeat (3) @(negedge clk);
        chk("rst_en",   {31'd0, en0},   32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_ack",  {31'd0, ack0},  32'd0);
        chk("rst_addr", {16'd0, addr0}, 32'd0);
        chk("rst_rdata",{16'd0, rdata0},32'd0);
        nRESET = 1'b1;
        repeat (2) @(negedge clk);

        // Reset asserted in the middle of a strobe
        req = 1'b1; rnw = 1'b0; addr_in = 16'h0200; wdata = 16'h1111;
        repeat (4) @(negedge clk);
        chk("pre_rst_en", {31'd0, en0}, 32'd1);
        nRESET = 1'b0;
        #1;
        chk("arst_en",   {31'd0, en0},   32'd0);
        chk("arst_ack",  {31'd0, ack0},  32'd0);
        chk("arst_busy", {31'd0, busy0}, 32'd0);
        chk("arst_addr", {16'd0, addr0}, 32'd0);
        req = 1'b0;
        repeat (3) @(negedge clk);
        nRESET = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", {31'd0, busy0}, 32'd0);

        // Write, zero wait states
        run(1'b0, 16'h0300, 16'hA55A, 16'h0000, 0, 0, -1, 1'b0, r);
        chk("wr_en_first", r.en_first, 32'd2);
        chk("wr_en_cnt",   r.en_cnt,   32'd6);
        chk("wr_ack_k",    r.ack_k,    32'd10);
        chk("wr_ack_cnt",  r.ack_cnt,  32'd1);
        chk("wr_err",      {31'd0, r.err}, 32'd0);
        chk("wr_doe",      {31'd0, r.doe_ok}, 32'd1);
        chk("wr_dir",      {31'd0, r.dir_ok}, 32'd1);
        chk("wr_dout",     {16'd0, r.dout}, 32'h0000A55A);
        chk("wr_addr",     {16'd0, r.addr}, 32'h00000300);
        chk("wr_overlap",  {31'd0, r.overlap}, 32'd0);

        // Read, zero wait states
        run(1'b1, 16'h0310, 16'hFFFF, 16'h1234, 0, 0, -1, 1'b0, r);
        chk("rd_rdata",  {16'd0, r.rdata}, 32'h00001234);
        chk("rd_ack_k",  r.ack_k, 32'd10);
        chk("rd_dir",    {31'd0, r.dir_ok}, 32'd1);
        chk("rd_doe",    {31'd0, r.doe_ok}, 32'd1);
        chk("rd_err",    {31'd0, r.err}, 32'd0);

        // Read with IOCHRDY low for 20 clocks from strobe start
        run(1'b1, 16'h0320, 16'h0000, 16'h5A5A, 2, 22, -1, 1'b0, r);
        chk("wt_en_cnt", r.en_cnt, 32'd23);
        chk("wt_ack_k",  r.ack_k,  32'd27);
        chk("wt_err",    {31'd0, r.err}, 32'd0);
        chk("wt_rdata",  {16'd0, r.rdata}, 32'h00005A5A);
        chk("wt_overlap",{31'd0, r.overlap}, 32'd0);
        repeat (4) @(negedge clk);

        // IOCHRDY stuck low, WAIT_MAX = 8 instance
        sel8 = 1'b1;
        run(1'b1, 16'h0330, 16'h0000, 16'hBEEF, 0, 1000, -1, 1'b0, r);
        chk("to_en_first", r.en_first, 32'd2);
        chk("to_en_cnt",   r.en_cnt,   32'd14);
        chk("to_ack_k",    r.ack_k,    32'd18);
        chk("to_err",      {31'd0, r.err}, 32'd1);
        chk("to_ack_cnt",  r.ack_cnt,  32'd1);
        // let the default-timing instance drain its own long wait
        repeat (10) @(negedge clk);

        // Next request clears err
        run(1'b0, 16'h0340, 16'h00C3, 16'h0000, 0, 0, -1, 1'b0, r);
        chk("clr_err",   {31'd0, r.err}, 32'd0);
        chk("clr_ack_k", r.ack_k, 32'd10);
        sel8 = 1'b0;

        // Abort in the second strobe clock, req held after ack
        run(1'b0, 16'h0350, 16'h7777, 16'h0000, 0, 0, 3, 1'b1, r);
        chk("ab_en_cnt", r.en_cnt, 32'd2);
        chk("ab_ack_k",  r.ack_k,  32'd6);
        chk("ab_err",    {31'd0, r.err}, 32'd1);
        nSLAVEN = 1'b0;
        en_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (en0 || ack0) en_seen++;
        end
        chk("ab_no_restart", en_seen, 32'd0);
        chk("ab_busy_done",  {31'd0, busy0}, 32'd1);
        req = 1'b0;
        @(negedge clk);
        chk("ab_idle", {31'd0, busy0}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
